// File: rtl/store_data_align.sv
// rtl/store_data_align.sv - RV32I store-side byte-lane formatter with req/ack bus beats
//
// Purpose:
//   Takes SB/SH/SW requests from execute, places the low byte/half/word of
//   rs2 on the correct byte lanes of a 32-bit word bus and generates byte
//   enables. Stores that cross a word boundary are either split into two
//   word-aligned beats (SPLIT_MISALIGNED=1) or rejected (SPLIT_MISALIGNED=0).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   st_valid   in   store request valid
//   st_ready   out  idle and able to accept (registered)
//   st_funct3  in   store funct3 (000 SB, 001 SH, 010 SW)
//   st_addr    in   byte address
//   st_data    in   rs2 value
//   mem_req    out  bus write request
//   mem_addr   out  word-aligned bus address
//   mem_wdata  out  lane-aligned write data, disabled lanes driven 0
//   mem_be     out  byte enables, bit i covers mem_wdata[8i+7:8i]
//   mem_ack    in   bus beat accepted
//   st_done    out  one-cycle pulse when the store has fully completed
//   st_err     out  one-cycle pulse when a request is rejected

module store_data_align #(
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [2:0]            st_funct3,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [31:0]           st_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  output logic                  st_done,
  output logic                  st_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  st_ready_q, st_ready_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  st_done_q, st_done_d;
  logic                  st_err_q, st_err_d;

  // Second-beat payload, captured at accept so the input side is free
  // while beat0 is still waiting for its ack.
  logic                  need_b1_q, need_b1_d;
  logic [ADDR_WIDTH-1:0] b1_addr_q, b1_addr_d;
  logic [31:0]           b1_wdata_q, b1_wdata_d;
  logic [3:0]            b1_be_q, b1_be_d;

  // ---------------------------------------------------------------------
  // Request decode and lane computation (combinational on request inputs)
  // ---------------------------------------------------------------------
  logic [1:0]            off;
  logic [3:0]            size_mask;
  logic                  legal_f3;
  logic [31:0]           data_masked;
  logic [63:0]           wide_data;
  logic [7:0]            wide_be;
  logic                  crosses;
  logic                  reject;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign off = st_addr[1:0];

  always_comb begin
    size_mask = 4'b0000;
    legal_f3  = 1'b0;
    case (st_funct3)
      3'b000: begin size_mask = 4'b0001; legal_f3 = 1'b1; end
      3'b001: begin size_mask = 4'b0011; legal_f3 = 1'b1; end
      3'b010: begin size_mask = 4'b1111; legal_f3 = 1'b1; end
      default: begin size_mask = 4'b0000; legal_f3 = 1'b0; end
    endcase
  end

  // Masking before the shift keeps unused rs2 bytes off the bus, so every
  // lane whose enable is clear ends up driven 0.
  assign data_masked = st_data & {{8{size_mask[3]}}, {8{size_mask[2]}},
                                  {8{size_mask[1]}}, {8{size_mask[0]}}};
  assign wide_data   = {32'b0, data_masked} << {off, 3'b000};
  assign wide_be     = {4'b0000, size_mask} << off;

  // Any enable in the upper word means the access straddles two words;
  // this is exactly SH at off=3 and SW at off!=0.
  assign crosses = |wide_be[7:4];
  assign reject  = !legal_f3 || (crosses && (SPLIT_MISALIGNED == 1'b0));
  assign accept  = st_valid && st_ready_q;

  assign base_addr = {st_addr[ADDR_WIDTH-1:2], 2'b00};
  assign next_addr = base_addr + ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    need_b1_d   = need_b1_q;
    b1_addr_d   = b1_addr_q;
    b1_wdata_d  = b1_wdata_q;
    b1_be_d     = b1_be_q;
    st_done_d   = 1'b0;
    st_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reject) begin
            st_err_d = 1'b1;
          end else begin
            state_d     = S_BEAT0;
            mem_req_d   = 1'b1;
            mem_addr_d  = base_addr;
            mem_wdata_d = wide_data[31:0];
            mem_be_d    = wide_be[3:0];
            need_b1_d   = crosses;
            b1_addr_d   = next_addr;
            b1_wdata_d  = wide_data[63:32];
            b1_be_d     = wide_be[7:4];
          end
        end
      end

      S_BEAT0: begin
        if (mem_ack) begin
          if (need_b1_q) begin
            // Request stays high: beat1 follows with no idle cycle.
            state_d     = S_BEAT1;
            mem_addr_d  = b1_addr_q;
            mem_wdata_d = b1_wdata_q;
            mem_be_d    = b1_be_q;
            need_b1_d   = 1'b0;
          end else begin
            state_d     = S_IDLE;
            mem_req_d   = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            st_done_d   = 1'b1;
          end
        end
      end

      S_BEAT1: begin
        if (mem_ack) begin
          state_d     = S_IDLE;
          mem_req_d   = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          st_done_d   = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        mem_req_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_be_d    = '0;
        need_b1_d   = 1'b0;
      end
    endcase

    // Ready is a registered view of "next state is IDLE", so it rises on the
    // first edge after reset and in the cycle after the final ack.
    st_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      st_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      need_b1_q   <= 1'b0;
      b1_addr_q   <= '0;
      b1_wdata_q  <= '0;
      b1_be_q     <= '0;
    end else begin
      state_q     <= state_d;
      st_ready_q  <= st_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      st_done_q   <= st_done_d;
      st_err_q    <= st_err_d;
      need_b1_q   <= need_b1_d;
      b1_addr_q   <= b1_addr_d;
      b1_wdata_q  <= b1_wdata_d;
      b1_be_q     <= b1_be_d;
    end
  end

  assign st_ready  = st_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign st_done   = st_done_q;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_store_data_align.sv
// tb/tb_store_data_align.sv - directed self-checking bench for store_data_align

module tb_store_data_align;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_valid0;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_ack;
  logic        mem_ack0;

  logic        st_ready,  mem_req,  st_done,  st_err;
  logic [31:0] mem_addr,  mem_wdata;
  logic [3:0]  mem_be;
  logic        st_ready0, mem_req0, st_done0, st_err0;
  logic [31:0] mem_addr0, mem_wdata0;
  logic [3:0]  mem_be0;

  int total = 0;
  int bad   = 0;

  store_data_align #(.SPLIT_MISALIGNED(1'b1), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .st_done(st_done), .st_err(st_err)
  );

  store_data_align #(.SPLIT_MISALIGNED(1'b0), .ADDR_WIDTH(32)) dut_nosplit (
    .clk(clk), .reset(reset),
    .st_valid(st_valid0), .st_ready(st_ready0),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_be(mem_be0), .mem_ack(mem_ack0),
    .st_done(st_done0), .st_err(st_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    check({tag, "_req"},   {63'b0, mem_req}, 64'd1);
    check({tag, "_addr"},  {32'b0, mem_addr}, {32'b0, a});
    check({tag, "_be"},    {60'b0, mem_be}, {60'b0, be});
    check({tag, "_wdata"}, {32'b0, mem_wdata}, {32'b0, wd});
    check({tag, "_rdy"},   {63'b0, st_ready}, 64'd0);
  endtask

  // Present one request for exactly one edge (st_ready assumed 1).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    st_valid  = 1'b1;
    tick();
    st_valid  = 1'b0;
    st_funct3 = 3'b111;
    st_addr   = 32'hFFFF_FFFF;
    st_data   = 32'hFFFF_FFFF;
  endtask

  task automatic finish_ok(input string tag);
    check({tag, "_req_off"}, {63'b0, mem_req},  64'd0);
    check({tag, "_done"},    {63'b0, st_done},  64'd1);
    check({tag, "_err"},     {63'b0, st_err},   64'd0);
    check({tag, "_rdy"},     {63'b0, st_ready}, 64'd1);
    tick();
    check({tag, "_done_clr"}, {63'b0, st_done}, 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    st_valid  = 1'b0;
    st_valid0 = 1'b0;
    st_funct3 = 3'b000;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    mem_ack   = 1'b0;
    mem_ack0  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_rdy",  {63'b0, st_ready}, 64'd0);
    check("rst_req",  {63'b0, mem_req},  64'd0);
    check("rst_be",   {60'b0, mem_be},   64'd0);
    check("rst_done", {63'b0, st_done},  64'd0);
    check("rst_err",  {63'b0, st_err},   64'd0);
    reset = 1'b0;
    #1;
    check("rel_rdy0", {63'b0, st_ready}, 64'd0);
    tick();
    check("rel_rdy1", {63'b0, st_ready}, 64'd1);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    check("idle_ack_req",  {63'b0, mem_req}, 64'd0);
    check("idle_ack_done", {63'b0, st_done}, 64'd0);
    mem_ack = 1'b0;

    // SB to 0x1002, ack on first request cycle
    issue(3'b000, 32'h0000_1002, 32'hAABB_CCDD);
    beat("sb", 32'h0000_1000, 4'b0100, 32'h00DD_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    finish_ok("sb");

    // Misaligned SH split into two beats
    issue(3'b001, 32'h0000_2003, 32'h0000_1234);
    beat("sh_b0", 32'h0000_2000, 4'b1000, 32'h3400_0000);
    mem_ack = 1'b1;
    tick();
    check("sh_b0_nodone", {63'b0, st_done}, 64'd0);
    beat("sh_b1", 32'h0000_2004, 4'b0001, 32'h0000_0012);
    tick();
    mem_ack = 1'b0;
    finish_ok("sh");

    // Aligned SW with three wait states
    issue(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("sw_w%0d", i), 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
      check($sformatf("sw_w%0d_done", i), {63'b0, st_done}, 64'd0);
      mem_ack = (i == 3);
      tick();
    end
    mem_ack = 1'b0;
    finish_ok("sw");

    // Illegal funct3
    issue(3'b011, 32'h0000_0040, 32'h1234_5678);
    check("ill_err", {63'b0, st_err},   64'd1);
    check("ill_req", {63'b0, mem_req},  64'd0);
    check("ill_rdy", {63'b0, st_ready}, 64'd1);
    check("ill_done", {63'b0, st_done}, 64'd0);
    tick();
    check("ill_err_clr", {63'b0, st_err}, 64'd0);
    check("ill_req2",    {63'b0, mem_req}, 64'd0);

    // Misaligned SW on the non-splitting instance
    st_funct3 = 3'b010;
    st_addr   = 32'h0000_0101;
    st_data   = 32'hCAFE_F00D;
    st_valid0 = 1'b1;
    tick();
    st_valid0 = 1'b0;
    check("ns_err", {63'b0, st_err0},   64'd1);
    check("ns_req", {63'b0, mem_req0},  64'd0);
    check("ns_rdy", {63'b0, st_ready0}, 64'd1);
    tick();
    check("ns_err_clr", {63'b0, st_err0}, 64'd0);
    check("ns_req2",    {63'b0, mem_req0}, 64'd0);

    // Address wrap on a split SW
    issue(3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
    beat("wr_b0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    beat("wr_b1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    tick();
    beat("wr_b1_hold", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    finish_ok("wr");

    // Reset during BEAT1
    issue(3'b001, 32'h0000_2003, 32'h0000_ABCD);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    beat("rm_b1", 32'h0000_2004, 4'b0001, 32'h0000_00AB);
    #2;
    reset = 1'b1;
    #1;
    check("rm_req",  {63'b0, mem_req},   64'd0);
    check("rm_addr", {32'b0, mem_addr},  64'd0);
    check("rm_wd",   {32'b0, mem_wdata}, 64'd0);
    check("rm_be",   {60'b0, mem_be},    64'd0);
    check("rm_rdy",  {63'b0, st_ready},  64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rm_rel_rdy",  {63'b0, st_ready}, 64'd0);
    check("rm_rel_done", {63'b0, st_done},  64'd0);
    tick();
    check("rm_rdy1", {63'b0, st_ready}, 64'd1);
    check("rm_done", {63'b0, st_done},  64'd0);
    issue(3'b000, 32'h0000_0003, 32'h0000_0055);
    beat("rm_sb", 32'h0000_0000, 4'b1000, 32'h5500_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    finish_ok("rm_sb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
